// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// One byte per frame with single-cycle valid / frame_err / parity_err strobes.
module uart_rx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 38000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxPin,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int DIV    = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SAMP_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t              state;
    state_t              next_state;
    logic                sync_1;
    logic                rx_s;
    logic [DIV_W-1:0]    div_cnt;
    logic [SAMP_W-1:0]   samp_cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          shift;
    logic                tick;
    logic                mid_hit;
    logic                bit_hit;
    logic                realign;
    logic                shift_en;
    logic                set_valid;
    logic                set_ferr;
    logic                set_perr;
`ifdef UART_RX_PARITY_EN
    logic                par_bad;
    logic                par_en;
`endif

    // rxPin is asynchronous; only the second flop output is ever used.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= rxPin;
            rx_s   <= sync_1;
        end
    end

    assign tick    = (div_cnt == DIV_LAST);
    assign mid_hit = tick && (samp_cnt == SAMP_MID);
    assign bit_hit = tick && (samp_cnt == SAMP_LAST);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // After the start-bit midpoint the sample counter is zeroed, so every
    // later wrap of the counter lands in the middle of a bit.
    always_comb begin
        next_state = state;
        realign    = 1'b0;
        shift_en   = 1'b0;
        set_valid  = 1'b0;
        set_ferr   = 1'b0;
        set_perr   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    next_state = S_START;
                end
            end
            S_START: begin
                if (mid_hit) begin
                    if (rx_s) begin
                        next_state = S_IDLE;
                    end else begin
                        next_state = S_DATA;
                        realign    = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (bit_hit) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        next_state = S_PARITY;
`else
                        next_state = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_hit) begin
                    par_en     = 1'b1;
                    next_state = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_hit) begin
                    if (!rx_s) begin
                        set_ferr   = 1'b1;
                        next_state = S_BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad) begin
                        set_perr   = 1'b1;
                        next_state = S_IDLE;
`endif
                    end else begin
                        set_valid  = 1'b1;
                        next_state = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Divider and sample counter sit at zero whenever no bit timing is needed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            samp_cnt <= '0;
            bit_idx  <= 3'd0;
        end else if (state == S_IDLE || state == S_BREAK) begin
            div_cnt  <= '0;
            samp_cnt <= '0;
            bit_idx  <= 3'd0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (realign) begin
                samp_cnt <= '0;
                bit_idx  <= 3'd0;
            end else begin
                if (tick) begin
                    samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
                end
                if (shift_en) begin
                    bit_idx <= bit_idx + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift <= 8'h00;
        end else if (shift_en) begin
            shift <= {rx_s, shift[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the received parity bit must equal the XOR of the data bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            par_bad <= 1'b0;
        end else if (state == S_IDLE) begin
            par_bad <= 1'b0;
        end else if (par_en) begin
            par_bad <= rx_s ^ (^shift);
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= set_valid;
            frame_err <= set_ferr;
            if (set_valid) begin
                data <= shift;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= set_perr;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames with baud skew,
// checked against a frame-level model of the receiver.
module tb_uart_rx;

    localparam int CLK_HZ = 2432000;
    localparam int BAUD   = 38000;
    localparam int OS     = 16;
    localparam int BIT    = (CLK_HZ / (BAUD * OS)) * OS;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       rxPin;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int vcnt = 0, fcnt = 0, pcnt = 0, viol = 0;
    int exp_v = 0, exp_f = 0, exp_p = 0;
    logic [7:0] exp_data = 8'h00;
    int valid_cycle = -1;
    bit prev_strobe = 1'b0;
    int start_cycle, lat, len, gap;
    logic [7:0] rb;
    logic rstop, rpar;

    uart_rx #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .OVERSAMPLE(OS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rxPin(rxPin),
        .data(data),
        .valid(valid),
        .frame_err(frame_err),
        .parity_err(parity_err),
        .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle++;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clock) begin : monitor
        int n;
        n = int'(valid) + int'(frame_err) + int'(parity_err);
        if (n > 1) viol++;
        if (n > 0 && prev_strobe) viol++;
        prev_strobe = (n > 0);
        if (valid) begin
            vcnt++;
            valid_cycle = cycle;
        end
        if (frame_err) fcnt++;
        if (parity_err) pcnt++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clock);
            #1;
        end
    endtask

    // Frame-level model: a low stop bit is a framing error, else a parity
    // mismatch (8E1 only) is a parity error, else the byte is delivered.
    task automatic expectFrame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
        if (!stop_bit) begin
            exp_f++;
        end else if (PAR && (par_bit != ^b)) begin
            exp_p++;
        end else begin
            exp_v++;
            exp_data = b;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input logic par_bit,
                                 input int bit_len, input int tail_low);
        expectFrame(b, stop_bit, par_bit);
        rxPin = 1'b0;
        waitClocks(bit_len);
        for (int i = 0; i < 8; i++) begin
            rxPin = b[i];
            waitClocks(bit_len);
        end
        if (PAR) begin
            rxPin = par_bit;
            waitClocks(bit_len);
        end
        rxPin = stop_bit;
        waitClocks(bit_len);
        if (tail_low > 0) begin
            rxPin = 1'b0;
            waitClocks(tail_low);
        end
        rxPin = 1'b1;
    endtask

    task automatic checkFrame(input string tag);
        checkOutput({tag, "_valid_count"}, vcnt, exp_v);
        checkOutput({tag, "_frame_err_count"}, fcnt, exp_f);
        checkOutput({tag, "_parity_err_count"}, pcnt, exp_p);
        checkOutput({tag, "_data"}, data, exp_data);
    endtask

    initial begin
        rxPin = 1'b1;
        reset = 1'b0;
        waitClocks(4);
        checkOutput("reset_data", data, 8'h00);
        checkOutput("reset_valid", valid, 1'b0);
        checkOutput("reset_frame_err", frame_err, 1'b0);
        checkOutput("reset_parity_err", parity_err, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        reset = 1'b1;
        waitClocks(10);
        checkOutput("idle_busy", busy, 1'b0);

        // Single frame, including start-edge to valid latency.
        valid_cycle = -1;
        start_cycle = cycle;
        applyStimulus(8'hA5, 1'b1, ^8'hA5, BIT, 0);
        waitClocks(8);
        checkFrame("a5");
        checkOutput("a5_busy", busy, 1'b0);
        lat = valid_cycle - start_cycle;
        checkOutput("a5_latency", 32'((lat >= BIT * 19 / 2 + PAR * BIT) && (lat <= BIT * 19 / 2 + PAR * BIT + 5)), 1);

        // Back-to-back frames with no idle gap.
        applyStimulus(8'h00, 1'b1, 1'b0, BIT, 0);
        checkFrame("b2b_00");
        applyStimulus(8'hFF, 1'b1, 1'b0, BIT, 0);
        waitClocks(8);
        checkFrame("b2b_ff");

        // Short glitch must be rejected before 0.6 bit.
        rxPin = 1'b0;
        waitClocks(BIT * 3 / 10);
        rxPin = 1'b1;
        waitClocks(BIT * 6 / 10 - BIT * 3 / 10);
        checkOutput("glitch_busy", busy, 1'b0);
        waitClocks(BIT);
        checkFrame("glitch");

        // Low stop bit, line held low for 3 bits total, then a good frame.
        applyStimulus(8'h3C, 1'b0, ^8'h3C, BIT, 2 * BIT);
        waitClocks(8);
        checkFrame("break");
        checkOutput("break_busy", busy, 1'b0);
        applyStimulus(8'h12, 1'b1, ^8'h12, BIT, 0);
        waitClocks(8);
        checkFrame("after_break");

        // Reset in the middle of a frame.
        rxPin = 1'b0;
        waitClocks(BIT);
        for (int i = 0; i < 4; i++) begin
            rxPin = (i % 2 == 0);
            waitClocks(BIT);
        end
        reset = 1'b0;
        waitClocks(3);
        rxPin = 1'b1;
        checkOutput("midreset_busy", busy, 1'b0);
        exp_data = 8'h00;
        waitClocks(3);
        reset = 1'b1;
        waitClocks(2 * BIT);
        checkFrame("midreset");
        applyStimulus(8'h5A, 1'b1, ^8'h5A, BIT, 0);
        waitClocks(8);
        checkFrame("after_reset");

`ifdef UART_RX_PARITY_EN
        applyStimulus(8'h81, 1'b1, 1'b0, BIT, 0);
        waitClocks(8);
        checkFrame("par_good");
        applyStimulus(8'h81, 1'b1, 1'b1, BIT, 0);
        waitClocks(8);
        checkFrame("par_bad");
`endif

        // Random frames with bit period skewed by about +/-1.6%.
        for (int k = 0; k < 10; k++) begin
            rb    = 8'($urandom);
            len   = BIT - 1 + int'($urandom_range(0, 2));
            rstop = ($urandom_range(0, 4) != 0);
            rpar  = ($urandom_range(0, 3) == 0) ? ~(^rb) : ^rb;
            gap   = rstop ? int'($urandom_range(0, BIT)) : int'($urandom_range(4, BIT));
            applyStimulus(rb, rstop, rpar, len, 0);
            checkFrame("rand");
            waitClocks(gap);
        end
        waitClocks(8);
        checkOutput("final_busy", busy, 1'b0);
        checkOutput("strobe_rules", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
